// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and frame-format constants
// used by both the transmitter and the receiver so the two ends agree.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam logic LINE_MARK  = 1'b1;
    localparam logic LINE_SPACE = 1'b0;

    localparam int DEF_CLK_DIV    = 16;
    localparam int DEF_DATA_BITS  = 8;
    localparam int DEF_PARITY_EN  = 0;
    localparam int DEF_PARITY_ODD = 0;
    localparam int DEF_STOP_BITS  = 1;

    function automatic int frame_bits(input int data_bits, input int parity_en,
                                      input int stop_bits);
        return 1 + data_bits + parity_en + stop_bits;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Divide-by-CLK_DIV bit-period counter with synchronous restart; tick marks
// the last clock cycle of each bit period.
module uart_baud_tick #(
    parameter int CLK_DIV = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart || (cnt_q == CNT_LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready byte intake, LSB-first serialisation with
// optional parity and 1 or 2 stop bits, registered line output.
//
// state     | meaning
// ST_IDLE   | line at mark, ready for a byte
// ST_START  | start bit (space) for one bit period
// ST_DATA   | DATA_BITS data bits, shift register bit 0 on the line
// ST_PARITY | parity bit, present only when PARITY_EN
// ST_STOP   | STOP_BITS stop bits; last cycle may accept the next byte
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int PARITY_EN  = DEF_PARITY_EN,
    parameter int PARITY_ODD = DEF_PARITY_ODD,
    parameter int STOP_BITS  = DEF_STOP_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic STOP_LAST = (STOP_BITS == 2);
    localparam logic ODD_SEL = (PARITY_ODD != 0);

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 stop_q, stop_d;
    logic                 parity_q, parity_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;
    logic                 tick;
    logic                 restart;
    logic                 accept;

    // The bit-period counter is held at zero while idle and realigned on
    // every state change, so each state spans whole bit periods.
    assign restart = (state_q == ST_IDLE) || (state_d != state_q);

    uart_baud_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .restart(restart),
        .tick   (tick)
    );

    assign tx_ready = (state_q == ST_IDLE) ||
                      ((state_q == ST_STOP) && tick && (stop_q == STOP_LAST));
    assign accept   = tx_valid && tx_ready;

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        stop_d   = stop_q;
        parity_d = parity_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d = ST_DATA;
                    idx_d   = '0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == IDX_LAST) begin
                        state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                        stop_d  = 1'b0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_d = ST_STOP;
                    stop_d  = 1'b0;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (stop_q == STOP_LAST) begin
                        done_d  = 1'b1;
                        state_d = accept ? ST_START : ST_IDLE;
                    end else begin
                        stop_d = stop_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Parity is taken from the latched byte, never from the live input.
        if (accept) begin
            shift_d  = tx_data;
            parity_d = (^tx_data) ^ ODD_SEL;
            idx_d    = '0;
            stop_d   = 1'b0;
        end

        case (state_q)
            ST_START:  tx_d = LINE_SPACE;
            ST_DATA:   tx_d = shift_q[0];
            ST_PARITY: tx_d = parity_q;
            default:   tx_d = LINE_MARK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            shift_q  <= '0;
            idx_q    <= '0;
            stop_q   <= 1'b0;
            parity_q <= 1'b0;
            tx_q     <= LINE_MARK;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            stop_q   <= stop_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
            done_q   <= done_d;
        end
    end

    assign tx      = tx_q;
    assign tx_busy = (state_q != ST_IDLE);
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four frame formats (8N1, 8E1, 8O1, 8N2) at CLK_DIV=4,
// expected line bits queued at accept and compared cycle by cycle on the pin.
module tb_uart_tx;

    localparam int CDIV = 4;
    localparam int PER  = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       valid  [4];
    logic       ready_w[4];
    logic       tx_w   [4];
    logic       busy_w [4];
    logic       done_w [4];

    int cfg_pe  [4] = '{0, 1, 1, 0};
    int cfg_odd [4] = '{0, 0, 1, 0};
    int cfg_stop[4] = '{1, 1, 1, 2};

    int checks   = 0;
    int failures = 0;
    int acc_cnt [4] = '{0, 0, 0, 0};
    int done_cnt[4] = '{0, 0, 0, 0};

    logic  exp_bits[$];
    int    sel;
    bit    mon_en;
    bit    in_frame;
    time   last_start;
    time   prev_start;

    always #(PER/2) clk = ~clk;

    uart_tx #(.CLK_DIV(CDIV), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_n1 (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(valid[0]),
        .tx_ready(ready_w[0]), .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]));
    uart_tx #(.CLK_DIV(CDIV), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_e1 (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(valid[1]),
        .tx_ready(ready_w[1]), .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]));
    uart_tx #(.CLK_DIV(CDIV), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_o1 (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(valid[2]),
        .tx_ready(ready_w[2]), .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]));
    uart_tx #(.CLK_DIV(CDIV), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_n2 (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(valid[3]),
        .tx_ready(ready_w[3]), .tx(tx_w[3]), .tx_busy(busy_w[3]), .tx_done(done_w[3]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int frame_len(input int d);
        return (1 + 8 + cfg_pe[d] + cfg_stop[d]) * CDIV;
    endfunction

    task automatic push_frame(input int d, input logic [7:0] b);
        exp_bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
        if (cfg_pe[d] != 0) exp_bits.push_back((^b) ^ (cfg_odd[d] != 0));
        for (int i = 0; i < cfg_stop[d]; i++) exp_bits.push_back(1'b1);
    endtask

    task automatic send(input int d, input logic [7:0] b, input bit keep, input bit push);
        int n;
        @(posedge clk); #1;
        tx_data  = b;
        valid[d] = 1'b1;
        n = 0;
        @(negedge clk);
        while (!ready_w[d] && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!ready_w[d]) begin
            chk("accept_timeout", 0, 1);
            valid[d] = 1'b0;
            return;
        end
        if (push) push_frame(d, b);
        @(posedge clk); #1;
        if (!keep) valid[d] = 1'b0;
    endtask

    task automatic wait_frames_done();
        int n;
        n = 0;
        @(negedge clk);
        while ((exp_bits.size() != 0 || in_frame) && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk("frames_drained", (exp_bits.size() == 0 && !in_frame), 1);
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (!rst && valid[i] && ready_w[i]) acc_cnt[i]++;
            if (done_w[i]) done_cnt[i]++;
        end
    end

    // Monitor: on the first low cycle of a frame, walk every cycle of it.
    initial begin : monitor
        int   d;
        int   f;
        logic bexp;
        bexp = 1'b1;
        forever begin
            @(negedge clk);
            if (mon_en && tx_w[sel] == 1'b0) begin
                d = sel;
                f = frame_len(d);
                in_frame   = 1'b1;
                prev_start = last_start;
                last_start = $time;
                for (int o = 0; o < f; o++) begin
                    if (o > 0) @(negedge clk);
                    if (!mon_en) break;
                    if (o % CDIV == 0) begin
                        if (exp_bits.size() == 0) begin
                            chk("unexpected_frame", 1, 0);
                            break;
                        end
                        bexp = exp_bits.pop_front();
                    end
                    chk("tx_bit", tx_w[d], bexp);
                    chk("tx_done", done_w[d], (o == f - 1));
                    if (o <= f - 2) begin
                        chk("tx_ready", ready_w[d], (o == f - 2));
                        chk("tx_busy", busy_w[d], 1);
                    end
                end
                in_frame = 1'b0;
            end
        end
    end

    initial begin
        int a0;
        rst      = 1'b1;
        tx_data  = '0;
        mon_en   = 1'b1;
        in_frame = 1'b0;
        sel      = 0;
        last_start = 0;
        prev_start = 0;
        for (int i = 0; i < 4; i++) valid[i] = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("rst_tx", tx_w[i], 1);
            chk("rst_ready", ready_w[i], 1);
            chk("rst_busy", busy_w[i], 0);
            chk("rst_done", done_w[i], 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        // single byte 8N1
        sel = 0;
        send(0, 8'h55, 0, 1);
        wait_frames_done();

        // even and odd parity, two stop bits
        sel = 1;
        send(1, 8'hA3, 0, 1);
        wait_frames_done();
        sel = 2;
        send(2, 8'hA3, 0, 1);
        wait_frames_done();
        sel = 3;
        send(3, 8'h00, 0, 1);
        wait_frames_done();

        // back-to-back with tx_valid held
        sel = 0;
        a0 = acc_cnt[0];
        send(0, 8'h12, 1, 1);
        send(0, 8'h34, 0, 1);
        wait_frames_done();
        chk("b2b_gap", 32'(last_start - prev_start), 32'(40 * PER));
        chk("b2b_accepts", acc_cnt[0] - a0, 2);

        // tx_data changed and tx_valid raised while busy
        a0 = acc_cnt[0];
        send(0, 8'h5A, 0, 1);
        repeat (10) @(posedge clk);
        #1;
        tx_data  = 8'hC3;
        valid[0] = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        valid[0] = 1'b0;
        wait_frames_done();
        chk("stall_accepts", acc_cnt[0] - a0, 1);

        // reset during data bit 3, with tx_valid asserted alongside reset
        mon_en = 1'b0;
        send(0, 8'hB6, 0, 0);
        repeat (17) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_bit3", tx_w[0], 0);
        a0 = acc_cnt[0];
        @(posedge clk); #1;
        rst      = 1'b1;
        valid[0] = 1'b1;
        tx_data  = 8'h00;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_tx", tx_w[0], 1);
        chk("midrst_ready", ready_w[0], 1);
        chk("midrst_busy", busy_w[0], 0);
        chk("midrst_done", done_w[0], 0);
        @(posedge clk); #1;
        rst      = 1'b0;
        valid[0] = 1'b0;
        chk("rst_no_accept", acc_cnt[0] - a0, 0);
        repeat (3) @(posedge clk);
        mon_en = 1'b1;
        send(0, 8'hFF, 0, 1);
        wait_frames_done();

        repeat (4) @(posedge clk);
        chk("done_count_n1", done_cnt[0], 5);
        chk("done_count_e1", done_cnt[1], 1);
        chk("done_count_o1", done_cnt[2], 1);
        chk("done_count_n2", done_cnt[3], 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
